// File: rtl/landing_request_queue.sv
// Landing request buffer: emergency and normal FIFOs feeding runway_picker one request at a time,
// emergency first, with a programmable idle gap between issues and a tower hold.
module landing_request_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned GAP   = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  input  logic [1:0]    req_dir,
  input  logic          req_emerg,
  output logic          req_ready,
  input  logic          hold,
  output logic          en,
  output logic [1:0]    d,
  output logic [CW-1:0] cnt_emerg,
  output logic [CW-1:0] cnt_norm
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            en_q, en_d;
  logic [1:0]      d_q, d_d;

  logic [1:0]      mem_e_q [DEPTH];
  logic [1:0]      mem_e_d [DEPTH];
  logic [1:0]      mem_n_q [DEPTH];
  logic [1:0]      mem_n_d [DEPTH];
  logic [AW-1:0]   wp_e_q, wp_e_d, rp_e_q, rp_e_d;
  logic [AW-1:0]   wp_n_q, wp_n_d, rp_n_q, rp_n_d;
  logic [CW-1:0]   cnt_e_q, cnt_e_d, cnt_n_q, cnt_n_d;

  logic            push_e, push_n, pop_e, pop_n, start;

  // Readiness uses registered counts only, so a same-cycle pop never frees a full FIFO.
  always_comb begin
    req_ready = req_emerg ? (cnt_e_q != CW'(DEPTH)) : (cnt_n_q != CW'(DEPTH));
    push_e    = req_valid && req_ready && req_emerg;
    push_n    = req_valid && req_ready && !req_emerg;
    start     = (state_q == StIdle) && !hold && ((cnt_e_q != '0) || (cnt_n_q != '0));
    pop_e     = start && (cnt_e_q != '0);
    pop_n     = start && (cnt_e_q == '0);
  end

  always_comb begin
    mem_e_d = mem_e_q;
    mem_n_d = mem_n_q;
    wp_e_d  = wp_e_q;
    rp_e_d  = rp_e_q;
    wp_n_d  = wp_n_q;
    rp_n_d  = rp_n_q;
    if (push_e) begin
      mem_e_d[wp_e_q] = req_dir;
      wp_e_d          = wp_e_q + AW'(1);
    end
    if (push_n) begin
      mem_n_d[wp_n_q] = req_dir;
      wp_n_d          = wp_n_q + AW'(1);
    end
    if (pop_e) rp_e_d = rp_e_q + AW'(1);
    if (pop_n) rp_n_d = rp_n_q + AW'(1);
    cnt_e_d = cnt_e_q + CW'(push_e) - CW'(pop_e);
    cnt_n_d = cnt_n_q + CW'(push_n) - CW'(pop_n);
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    en_d    = 1'b0;
    d_d     = d_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StIssue;
          en_d    = 1'b1;
          d_d     = pop_e ? mem_e_q[rp_e_q] : mem_n_q[rp_n_q];
        end
      end
      StIssue: begin
        state_d = StGap;
        gap_d   = GW'(GAP - 1);
      end
      StGap: begin
        if (gap_q == '0) state_d = StIdle;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gap_q   <= '0;
      en_q    <= 1'b0;
      d_q     <= 2'b00;
      wp_e_q  <= '0;
      rp_e_q  <= '0;
      wp_n_q  <= '0;
      rp_n_q  <= '0;
      cnt_e_q <= '0;
      cnt_n_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_e_q[i] <= 2'b00;
        mem_n_q[i] <= 2'b00;
      end
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      en_q    <= en_d;
      d_q     <= d_d;
      wp_e_q  <= wp_e_d;
      rp_e_q  <= rp_e_d;
      wp_n_q  <= wp_n_d;
      rp_n_q  <= rp_n_d;
      cnt_e_q <= cnt_e_d;
      cnt_n_q <= cnt_n_d;
      mem_e_q <= mem_e_d;
      mem_n_q <= mem_n_d;
    end
  end

  assign en        = en_q;
  assign d         = d_q;
  assign cnt_emerg = cnt_e_q;
  assign cnt_norm  = cnt_n_q;

endmodule

// File: tb/tb_landing_request_queue.sv
// Randomized bench for landing_request_queue: a queue-based reference model predicts issues,
// and a negedge monitor compares the DUT against it through an expected-issue scoreboard.
module tb_landing_request_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned GAP   = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          req_valid = 1'b0;
  logic [1:0]    req_dir   = 2'b00;
  logic          req_emerg = 1'b0;
  logic          hold      = 1'b0;
  logic          req_ready;
  logic          en;
  logic [1:0]    d;
  logic [CW-1:0] cnt_emerg;
  logic [CW-1:0] cnt_norm;

  landing_request_queue #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_dir   (req_dir),
    .req_emerg (req_emerg),
    .req_ready (req_ready),
    .hold      (hold),
    .en        (en),
    .d         (d),
    .cnt_emerg (cnt_emerg),
    .cnt_norm  (cnt_norm)
  );

  always #5 clk = ~clk;

  int       n_checks = 0;
  int       n_fail   = 0;

  // Reference model: two plain queues plus the cycle of the last issue.
  bit [1:0] qe[$];
  bit [1:0] qn[$];
  bit [1:0] exp_q[$];
  bit       mdl_en   = 1'b0;
  bit [1:0] mdl_d    = 2'b00;
  int       cyc      = 0;
  int       last_iss = -100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    bit       iss;
    bit       rdy_e;
    bit       rdy_n;
    bit [1:0] dir;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      qe.delete();
      qn.delete();
      exp_q.delete();
      mdl_en   = 1'b0;
      mdl_d    = 2'b00;
      cyc      = 0;
      last_iss = -100;
    end else begin
      cyc++;
      rdy_e = (qe.size() != DEPTH);
      rdy_n = (qn.size() != DEPTH);
      iss   = !hold && (qe.size() + qn.size() != 0) && (cyc - last_iss >= int'(GAP) + 2);
      mdl_en = iss;
      if (iss) begin
        if (qe.size() != 0) dir = qe.pop_front();
        else                dir = qn.pop_front();
        mdl_d    = dir;
        last_iss = cyc;
        exp_q.push_back(dir);
      end
      if (req_valid) begin
        if (req_emerg && rdy_e)       qe.push_back(req_dir);
        else if (!req_emerg && rdy_n) qn.push_back(req_dir);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("en", en, mdl_en);
      check("d_held", d, mdl_d);
      check("cnt_emerg", cnt_emerg, qe.size());
      check("cnt_norm", cnt_norm, qn.size());
      check("req_ready", req_ready, req_emerg ? (qe.size() != DEPTH) : (qn.size() != DEPTH));
      if (en === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_issue: got unexpected en with d=%0d, required no issue at %0t", d, $time);
        end else begin
          check("sb_dir", d, exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input bit v, input bit em, input bit [1:0] dir, input bit h);
    @(posedge clk);
    #1;
    req_valid = v;
    req_emerg = em;
    req_dir   = dir;
    hold      = h;
  endtask

  task automatic idle(input int n, input bit h);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, h);
  endtask

  initial begin
    bit found;

    // Reset with a request offered throughout.
    req_valid = 1'b1;
    req_dir   = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    check("rst_en", en, 0);
    check("rst_d", d, 0);
    check("rst_cnt_emerg", cnt_emerg, 0);
    check("rst_cnt_norm", cnt_norm, 0);
    check("rst_ready_norm", req_ready, 1);
    req_emerg = 1'b1;
    #1;
    check("rst_ready_emerg", req_ready, 1);
    req_valid = 1'b0;
    req_emerg = 1'b0;
    rst_n     = 1'b1;
    idle(3, 1'b0);

    // Single normal request.
    step(1'b1, 1'b0, 2'b10, 1'b0);
    idle(12, 1'b0);

    // Emergency overtakes earlier normal requests.
    step(1'b1, 1'b0, 2'b01, 1'b1);
    step(1'b1, 1'b0, 2'b10, 1'b1);
    step(1'b1, 1'b1, 2'b11, 1'b1);
    idle(3, 1'b1);
    idle(25, 1'b0);

    // Full normal FIFO refuses the fifth push; emergency still accepted.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 2'(i), 1'b1);
    step(1'b1, 1'b1, 2'b01, 1'b1);
    idle(4, 1'b1);
    idle(40, 1'b0);

    // Reset during the ISSUE cycle.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'(i + 1), 1'b1);
    step(1'b0, 1'b0, 2'b00, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (en === 1'b1) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_issue: got no en within 20 cycles, required an issue");
    end
    rst_n = 1'b0;
    #1;
    check("midrst_en", en, 0);
    check("midrst_cnt_norm", cnt_norm, 0);
    check("midrst_cnt_emerg", cnt_emerg, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(20, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
           $urandom_range(0, 7) == 0);
    end
    idle(80, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
